mem_io_ctrl: RTL and testbench
==============================

Name: mem_io_ctrl

Overview:
- Memory/IO controller directly downstream of the CPU controller FSM.
- Consumes the FSM's memory command, address and store data, and drives a 256-word synchronous RAM.
- Implements memory-mapped LED and switch registers.
- Returns load/fetch data through a fixed 2-cycle read pipeline, so data is stable before the FSM's IR-load and Rd-write cycles.

Parameters:
- ADDR_W, 9, CPU word-address width
- DATA_W, 16, data word width
- LED_ADDR, 9'h100, address of the LED output register
- SW_ADDR, 9'h140, address of the switch input register

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  reset, synchronous and active-low (0 = reset)
- mem_cmd  in  2  00 none, 01 read, 10 write, 11 illegal
- mem_addr  in  ADDR_W  word address
- write_data  in  DATA_W  store data
- read_data  out  DATA_W  registered read result
- rd_valid  out  1  one-cycle pulse when read_data updates
- ram_addr  out  8  RAM address = mem_addr[7:0], combinational
- ram_we  out  1  RAM write enable, combinational
- ram_wdata  out  DATA_W  = write_data, combinational
- ram_rdata  in  DATA_W  RAM read data, valid one clock after address
- sw  in  10  asynchronous slide switches
- led  out  8  LED register
- err  out  1  sticky access-error flag

Behaviour:
- Reset (rst==0 at a rising edge) clears:
  - read_data=0, rd_valid=0, led=0, err=0;
  - pipeline registers and switch synchronizer to 0.
- Reset overrides any in-flight read or write. The LED write is suppressed in a reset cycle.
- Address decode:
  - RAM region: mem_addr[8]==0.
  - LED: mem_addr==LED_ADDR.
  - SW: mem_addr==SW_ADDR.
  - Anything else is unmapped.
- Write (mem_cmd==10):
  - ram_we=1 combinationally iff mem_addr[8]==0.
  - If mem_addr==LED_ADDR: led <= write_data[7:0] at the edge.
  - A write held for N cycles repeats the same write each cycle; this is harmless and required.
- Read pipeline, 2 cycles:
  - Stage S1 (edge k): capture v1 = (mem_cmd==01), the region select, and the LED value.
  - Stage S2 (edge k+1), if v1: read_data <= one of
    - ram_rdata (RAM region),
    - {6'b0, sw_sync} (SW),
    - {8'b0, led} (LED readback),
    - 16'h0000 (unmapped).
  - rd_valid <= v1 at edge k+1.
  - read_data holds its last value when no read completes.
- A read issued in cycle k is visible at read_data after edge k+1.
- Back-to-back reads pipeline at one per cycle.
- A read held constant for 3 cycles produces 3 rd_valid pulses with identical data.
- Read-after-write, same RAM address in consecutive cycles: the read returns the new data. The RAM is write-first; the controller adds no bypass.
- LED read in the cycle after an LED write: returns the new value. The S1 LED capture uses the post-write value via forwarding of write_data[7:0].
- Switch synchronizer: 2 flops, so sw_sync lags sw by 2 edges. A switch read sees the value synchronized at S1 time.
- err is set at the edge after any of:
  - mem_cmd==11;
  - a read or write to an unmapped address;
  - a write to SW_ADDR (ignored, no side effect).
- err stays set until reset.
- mem_cmd==00 produces no RAM, LED or read activity. ram_addr and ram_wdata still follow their inputs.
- No handshake and no stalls: the controller always accepts a command every cycle.

Test Plan:
- Reset then idle: rst=0 for 2 cycles -> read_data=0, led=0, err=0, rd_valid=0.
- RAM store then load: write addr 9'h005 data 16'hABCD for 1 cycle, then read 9'h005 -> rd_valid high exactly 2 edges after the read is issued, read_data=16'hABCD.
- LED write and readback: write 9'h100 data 16'h12A5 -> led=8'hA5 next edge; an immediate read of 9'h100 -> read_data=16'h00A5.
- Switch read: sw=10'h2F3 held, read 9'h140 after ≥3 cycles -> read_data=16'h02F3, err=0. A subsequent write to 9'h140 -> err=1, led unchanged.
- Illegal and unmapped: mem_cmd=11 -> err=1 next edge. Separately, after reset, read 9'h1FF -> read_data=0, err=1, no ram_we.
- Reset mid-read: issue read of 9'h003 (RAM=16'h7777), assert rst=0 on the next edge -> rd_valid stays 0 and read_data stays 0.

Source files
------------

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: memory/IO controller behind the CPU controller FSM.
// Drives a 256-word synchronous RAM and provides memory-mapped LED and
// switch registers. Load/fetch results come back through a fixed
// two-stage read pipeline, so read_data is stable one cycle after S1.
module mem_io_ctrl #(
  parameter int                unsigned ADDR_W   = 9,
  parameter int                unsigned DATA_W   = 16,
  parameter logic [ADDR_W-1:0]          LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0]          SW_ADDR  = 9'h140
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  output logic [7:0]        ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [9:0]        sw,
  output logic [7:0]        led,
  output logic              err
);

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_LED  = 2'd1,
    REG_SW   = 2'd2,
    REG_NONE = 2'd3
  } region_t;

  logic       is_rd, is_wr, is_ill;
  logic       is_ram, is_led, is_sw;
  logic       led_wr;
  logic       err_set;
  logic [7:0] led_next;
  region_t    region;

  // Read pipeline S1 registers and the switch synchronizer
  logic       v1;
  region_t    reg1;
  logic [7:0] led1;
  logic [9:0] sw1;
  logic [9:0] sw_meta, sw_sync;

  // Command and address decode
  always_comb begin
    is_rd  = (mem_cmd == 2'b01);
    is_wr  = (mem_cmd == 2'b10);
    is_ill = (mem_cmd == 2'b11);
    is_ram = ~mem_addr[ADDR_W-1];
    is_led = (mem_addr == LED_ADDR);
    is_sw  = (mem_addr == SW_ADDR);
    if (is_ram)      region = REG_RAM;
    else if (is_led) region = REG_LED;
    else if (is_sw)  region = REG_SW;
    else             region = REG_NONE;
    led_wr   = is_wr & is_led;
    // S1 LED capture sees a same-cycle LED write through this forward
    led_next = led_wr ? write_data[7:0] : led;
    err_set  = is_ill
             | ((is_rd | is_wr) & (region == REG_NONE))
             | (is_wr & is_sw);
  end

  assign ram_addr  = mem_addr[7:0];
  assign ram_we    = is_wr & is_ram;
  assign ram_wdata = write_data;

  // LED register, sticky error, switch sync and the two read stages
  always_ff @(posedge clk) begin
    if (!rst) begin
      read_data <= '0;
      rd_valid  <= 1'b0;
      led       <= '0;
      err       <= 1'b0;
      v1        <= 1'b0;
      reg1      <= REG_RAM;
      led1      <= '0;
      sw1       <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      led     <= led_next;
      if (err_set) err <= 1'b1;

      v1   <= is_rd;
      reg1 <= region;
      led1 <= led_next;
      sw1  <= sw_sync;

      rd_valid <= v1;
      if (v1) begin
        case (reg1)
          REG_RAM: read_data <= ram_rdata;
          REG_SW:  read_data <= DATA_W'(sw1);
          REG_LED: read_data <= DATA_W'(led1);
          default: read_data <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl with an external write-first RAM model
// and a read scoreboard keyed on the cycle each result is due.
module tb_mem_io_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        rd_valid;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [9:0]  sw;
  logic [7:0]  led;
  logic        err;

  mem_io_ctrl #(
    .ADDR_W  (9),
    .DATA_W  (16),
    .LED_ADDR(9'h100),
    .SW_ADDR (9'h140)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .write_data(write_data),
    .read_data (read_data),
    .rd_valid  (rd_valid),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .sw        (sw),
    .led       (led),
    .err       (err)
  );

  always #5 clk = ~clk;

  // External 256x16 synchronous RAM, write-first
  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram_we ? ram_wdata : ram[ram_addr];
  end

  typedef struct {
    int unsigned due;
    logic [15:0] data;
  } sb_t;

  sb_t         sbq[$];
  logic [15:0] shadow [256];
  int unsigned cyc    = 0;
  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge, then score the read-result port against the queue
  task automatic tick();
    logic exp_v;
    @(posedge clk);
    #1;
    cyc++;
    exp_v = (sbq.size() > 0) && (sbq[0].due == cyc);
    chk("rd_valid", 32'(rd_valid), 32'(exp_v));
    if (exp_v) begin
      chk("read_data", 32'(read_data), 32'(sbq[0].data));
      void'(sbq.pop_front());
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    mem_cmd    = 2'b10;
    mem_addr   = a;
    write_data = d;
    if (!a[8]) shadow[a[7:0]] = d;
    #1;
    chk("ram_we_wr", 32'(ram_we), 32'(!a[8]));
    chk("ram_addr", 32'(ram_addr), 32'(a[7:0]));
    chk("ram_wdata", 32'(ram_wdata), 32'(d));
    tick();
  endtask

  task automatic rd(input logic [8:0] a, input logic [15:0] expd);
    sb_t e;
    mem_cmd  = 2'b01;
    mem_addr = a;
    e.due    = cyc + 2;
    e.data   = expd;
    sbq.push_back(e);
    #1;
    chk("ram_we_rd", 32'(ram_we), 32'(0));
    tick();
  endtask

  task automatic idle(input int unsigned n);
    mem_cmd = 2'b00;
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int unsigned n);
    rst     = 1'b0;
    mem_cmd = 2'b00;
    sbq.delete();
    for (int unsigned i = 0; i < n; i++) tick();
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 16'h0000;
      shadow[i] = 16'h0000;
    end
    rst = 1'b0; mem_cmd = 2'b00; mem_addr = '0; write_data = '0; sw = '0;

    // Reset then idle
    do_reset(2);
    chk("rst_read_data", 32'(read_data), 32'(0));
    chk("rst_led", 32'(led), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    idle(1);

    // RAM store then load, back-to-back reads, held read, read-after-write
    wr(9'h005, 16'hABCD);
    rd(9'h005, 16'hABCD);
    idle(2);
    wr(9'h006, 16'h5A5A);
    rd(9'h005, shadow[8'h05]);
    rd(9'h006, shadow[8'h06]);
    rd(9'h005, shadow[8'h05]);
    rd(9'h005, shadow[8'h05]);
    rd(9'h005, shadow[8'h05]);
    idle(2);
    wr(9'h007, 16'h1234);
    rd(9'h007, 16'h1234);
    idle(2);
    mem_cmd  = 2'b00;
    mem_addr = 9'h009;
    write_data = 16'hBEEF;
    #1;
    chk("idle_ram_we", 32'(ram_we), 32'(0));
    chk("idle_ram_addr", 32'(ram_addr), 32'(8'h09));
    chk("idle_ram_wdata", 32'(ram_wdata), 32'(16'hBEEF));
    idle(1);

    // LED write and immediate readback
    wr(9'h100, 16'h12A5);
    chk("led_write", 32'(led), 32'(8'hA5));
    rd(9'h100, 16'h00A5);
    idle(2);
    chk("err_clean", 32'(err), 32'(0));

    // Switch read after synchronizer settles, then illegal switch write
    sw = 10'h2F3;
    idle(3);
    rd(9'h140, 16'h02F3);
    idle(2);
    chk("sw_err0", 32'(err), 32'(0));
    wr(9'h140, 16'hFFFF);
    chk("sw_wr_err", 32'(err), 32'(1));
    chk("sw_wr_led", 32'(led), 32'(8'hA5));
    idle(1);
    chk("err_sticky", 32'(err), 32'(1));

    // Illegal command
    do_reset(1);
    chk("rst2_err", 32'(err), 32'(0));
    chk("rst2_led", 32'(led), 32'(0));
    mem_cmd = 2'b11;
    tick();
    chk("ill_err", 32'(err), 32'(1));
    idle(1);

    // Unmapped read
    do_reset(1);
    rd(9'h1FF, 16'h0000);
    chk("unm_err", 32'(err), 32'(1));
    idle(2);

    // Reset mid-read
    do_reset(1);
    wr(9'h003, 16'h7777);
    rd(9'h003, 16'h7777);
    rst = 1'b0;
    mem_cmd = 2'b00;
    sbq.delete();
    tick();
    chk("midrst_data", 32'(read_data), 32'(0));
    rst = 1'b1;
    idle(2);
    chk("midrst_data2", 32'(read_data), 32'(0));

    // Confirm the RAM kept the store and drain
    rd(9'h003, 16'h7777);
    idle(3);
    chk("sb_empty", 32'(sbq.size()), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
